// File: rtl/div_issue_ctrl.sv
// Sign-handling front end for a registered unsigned divider: strips operand signs,
// waits out the divider latency, re-applies signs and returns one flagged result.
module div_issue_ctrl #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             rem_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       dest_in,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       dest_out,
    output logic             dz,
    output logic             ovf,
    output logic             zf,
    output logic             nf
);
    // Handshake: start is taken only while busy=0; busy then stays high until the
    // single done cycle has passed, and starts seen while busy are dropped.
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(LATENCY);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             signed_q, signed_d, rem_q, rem_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [2:0]       tag_q, tag_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, res_q, res_d;
    logic [2:0]       dest_q, dest_d;
    logic             dz_q, dz_d, ovf_q, ovf_d, zf_q, zf_d, nf_q, nf_d;

    logic [WIDTH-1:0] mag_a, mag_b, raw, fixed, new_res;
    logic [2:0]       new_dest;
    logic             is_ovf, negate, load, new_dz, new_ovf;

    // The most negative value maps onto itself, which is the right unsigned magnitude.
    assign mag_a  = (signed_op && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    assign mag_b  = (signed_op && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
    assign is_ovf = signed_op && (op_a == MIN_NEG) && (op_b == '1);

    // Truncating division: quotient sign follows the sign mismatch, remainder the dividend.
    assign raw    = rem_q ? div_remainder : div_quotient;
    assign negate = signed_q && (rem_q ? neg_a_q : (neg_a_q ^ neg_b_q));
    assign fixed  = negate ? (~raw + WIDTH'(1)) : raw;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        rem_d    = rem_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        tag_d    = tag_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        res_d    = res_q;
        dest_d   = dest_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        zf_d     = zf_q;
        nf_d     = nf_q;
        load     = 1'b0;
        new_res  = '0;
        new_dest = tag_q;
        new_dz   = 1'b0;
        new_ovf  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    signed_d = signed_op;
                    rem_d    = rem_sel;
                    tag_d    = dest_in;
                    neg_a_d  = op_a[WIDTH-1];
                    neg_b_d  = op_b[WIDTH-1];
                    if (op_b == '0) begin
                        state_d  = DONE;
                        load     = 1'b1;
                        new_dz   = 1'b1;
                        new_dest = dest_in;
                    end else if (is_ovf) begin
                        state_d  = DONE;
                        load     = 1'b1;
                        new_res  = rem_sel ? '0 : MIN_NEG;
                        new_ovf  = 1'b1;
                        new_dest = dest_in;
                    end else begin
                        dvd_d   = mag_a;
                        dvs_d   = mag_b;
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    load    = 1'b1;
                    new_res = fixed;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            res_d  = new_res;
            dest_d = new_dest;
            dz_d   = new_dz;
            ovf_d  = new_ovf;
            zf_d   = (new_res == '0);
            nf_d   = new_res[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            rem_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            tag_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            dest_q   <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            rem_q    <= rem_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            tag_q    <= tag_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
            dest_q   <= dest_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
        end
    end

    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign result       = res_q;
    assign dest_out     = dest_q;
    assign dz           = dz_q;
    assign ovf          = ovf_q;
    assign zf           = zf_q;
    assign nf           = nf_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: emulated registered divider, arithmetic reference model
// compared every cycle, plus directed literal cases.
module tb_div_issue_ctrl;
    localparam int W   = 16;
    localparam int LAT = 1;
    localparam logic [W-1:0] MINV = 16'h8000;

    logic         clk = 1'b0;
    logic         rst, start, signed_op, rem_sel;
    logic [W-1:0] op_a, op_b, div_dividend, div_divisor, div_quotient, div_remainder, result;
    logic [2:0]   dest_in, dest_out;
    logic         busy, done, dz, ovf, zf, nf;

    div_issue_ctrl #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .rem_sel(rem_sel),
        .op_a(op_a), .op_b(op_b), .dest_in(dest_in),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .busy(busy), .done(done), .result(result), .dest_out(dest_out),
        .dz(dz), .ovf(ovf), .zf(zf), .nf(nf)
    );

    always #5 clk = ~clk;

    // Registered unsigned divider, LAT edges deep
    logic [W-1:0] pq [LAT];
    logic [W-1:0] pr [LAT];
    initial for (int i = 0; i < LAT; i++) begin pq[i] = '0; pr[i] = '0; end
    always @(posedge clk) begin
        pq[0] <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
        pr[0] <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
        for (int i = 1; i < LAT; i++) begin pq[i] <= pq[i-1]; pr[i] <= pr[i-1]; end
    end
    assign div_quotient  = pq[LAT-1];
    assign div_remainder = pr[LAT-1];

    // Scoreboard counters
    int n_cmp = 0, n_bad = 0, m_dones = 0, dut_dones = 0, m_left = 0;
    bit armed = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mag(input bit s, input logic [W-1:0] v);
        if (s && $signed(v) < 0) return W'(-int'($signed(v)));
        return v;
    endfunction

    // Plain 32-bit arithmetic; truncating division matches the signed rules
    function automatic logic [W-1:0] ref_div(input bit s, input bit r, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int ia, ib;
        if (s) begin ia = int'($signed(a)); ib = int'($signed(b)); end
        else begin ia = int'(a); ib = int'(b); end
        return r ? W'(ia % ib) : W'(ia / ib);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return MINV;
            2: return '1;
            3: return 16'd1;
            default: return W'($urandom);
        endcase
    endfunction

    // Reference model: m_left = busy cycles still to come after this edge
    logic [W-1:0] m_dvd, m_dvs, m_res, p_res;
    logic [2:0]   m_dest, p_dest;
    bit           m_dz, m_ovf, m_zf, m_nf, p_dz, p_ovf;

    always @(posedge clk) begin
        armed = 1;
        if (rst) begin
            m_left = 0; m_dvd = '0; m_dvs = '0; m_res = '0; m_dest = '0;
            m_dz = 0; m_ovf = 0; m_zf = 0; m_nf = 0;
        end else if (m_left == 0) begin
            if (start) begin
                p_dest = dest_in;
                p_dz   = (op_b == 0);
                p_ovf  = signed_op && op_a == MINV && op_b == '1;
                p_res  = p_dz ? '0 : ref_div(signed_op, rem_sel, op_a, op_b);
                if (p_dz || p_ovf) m_left = 1;
                else begin
                    m_left = LAT + 2;
                    m_dvd  = mag(signed_op, op_a);
                    m_dvs  = mag(signed_op, op_b);
                end
            end
        end else begin
            m_left--;
        end
        if (m_left == 1) begin
            m_dones++;
            m_res = p_res; m_dest = p_dest; m_dz = p_dz; m_ovf = p_ovf;
            m_zf = (p_res == 0); m_nf = p_res[W-1];
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cycle",
                  {7'd0, div_dividend, div_divisor, busy, done, result, dest_out, dz, ovf, zf, nf},
                  {7'd0, m_dvd, m_dvs, m_left != 0, m_left == 1, m_res, m_dest, m_dz, m_ovf, m_zf, m_nf});
            if (done === 1'b1) dut_dones++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expects to be entered just after an edge with the DUT idle
    task automatic run_op(input string nm, input bit s, input bit r, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2:0] d, input logic [W-1:0] er,
                          input logic [3:0] eflags, input int ek);
        int k;
        signed_op = s; rem_sel = r; op_a = a; op_b = b; dest_in = d; start = 1;
        tick();
        start = 0;
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check({nm, "_lat"}, k, ek);
        check({nm, "_res"}, result, er);
        check({nm, "_flags"}, {dz, ovf, zf, nf}, eflags);
        check({nm, "_dest"}, dest_out, d);
        check({nm, "_model"}, m_res, er);
        tick();
    endtask

    initial begin
        int d0;
        rst = 1; start = 1; signed_op = 0; rem_sel = 0;
        op_a = 16'd798; op_b = 16'd11; dest_in = 3'd5;
        repeat (4) tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_res", result, 0);
        #1;
        rst = 0;
        run_op("u_q", 0, 0, 16'd798, 16'd11, 3'd5, 16'd72, 4'b0000, LAT + 1);
        run_op("u_r", 0, 1, 16'd798, 16'd11, 3'd2, 16'd6, 4'b0000, LAT + 1);
        run_op("s_q", 1, 0, 16'hFFF9, 16'd2, 3'd1, 16'hFFFD, 4'b0001, LAT + 1);
        run_op("s_r", 1, 1, 16'hFFF9, 16'd2, 3'd3, 16'hFFFF, 4'b0001, LAT + 1);
        run_op("s_r2", 1, 1, 16'd7, 16'hFFFE, 3'd4, 16'd1, 4'b0000, LAT + 1);
        run_op("dz", 0, 0, 16'd255, 16'd0, 3'd6, 16'd0, 4'b1010, 0);
        check("dz_dvd", div_dividend, 16'd7);
        check("dz_dvs", div_divisor, 16'd2);
        run_op("ovf", 1, 0, MINV, 16'hFFFF, 3'd7, MINV, 4'b0101, 0);
        check("ovf_dvd", div_dividend, 16'd7);

        // start held every cycle: only IDLE-cycle requests count
        for (int i = 0; i < 30; i++) begin
            start = 1; signed_op = 1'($urandom_range(0, 1)); rem_sel = 1'($urandom_range(0, 1));
            op_a = pick(); op_b = pick(); dest_in = 3'($urandom_range(0, 7));
            tick();
        end
        start = 0;
        repeat (LAT + 4) tick();

        // Reset during WAIT aborts without a done pulse
        d0 = dut_dones;
        signed_op = 0; rem_sel = 0; op_a = 16'd1000; op_b = 16'd3; dest_in = 3'd1; start = 1;
        tick();
        start = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("abort_res", result, 0);
        check("abort_busy", busy, 0);
        repeat (3) tick();
        check("abort_nodone", dut_dones, d0);
        run_op("after_rst", 0, 0, 16'd200, 16'd40, 3'd2, 16'd5, 4'b0000, LAT + 1);

        // Random traffic with sporadic resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            start = 1'($urandom_range(0, 1)); signed_op = 1'($urandom_range(0, 1));
            rem_sel = 1'($urandom_range(0, 1));
            op_a = pick(); op_b = pick(); dest_in = 3'($urandom_range(0, 7));
            tick();
        end
        rst = 0; start = 0;
        repeat (LAT + 4) tick();
        check("done_count", dut_dones, m_dones);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
